speed_select_ctrl: RTL
======================

// Module: speed_select_ctrl
// PURPOSE
//  Sequences the speed-selection screen and the game's movement timebase.
//  Shows the SPEED menu on start_req and latches the speed chosen by a
//  direction-key pulse. Then generates the periodic move_tick that steps the
//  game logic. Sits between the key debouncer and the screen mux / game FSM.
// PARAMETERS
//  DIV_FAST   2_500_000   tick period in clocks, level 0 (up key, super fast)
//  DIV_NORM   5_000_000   tick period in clocks, level 1 (down key, normal fast)
//  DIV_SLOW   7_500_000   tick period in clocks, level 2 (left key, normal slow)
//  DIV_VSLOW 12_500_000   tick period in clocks, level 3 (right key, super slow)
//  CNT_W      24          divider counter width; every DIV_* is in 2..2^CNT_W-1
// PORTS
//  vga_clk_25   in   1  25 MHz pixel/system clock
//  rst_n        in   1  asynchronous active-low reset
//  start_req    in   1  1-cycle pulse: open the speed menu
//  key_up       in   1  1-cycle debounced pulse
//  key_down     in   1  1-cycle debounced pulse
//  key_left     in   1  1-cycle debounced pulse
//  key_right    in   1  1-cycle debounced pulse
//  pause        in   1  level: freeze the divider while in RUN
//  game_over    in   1  1-cycle pulse: abort to IDLE
//  menu_active  out  1  high while the speed screen is to be displayed
//  speed_level  out  2  latched speed level 0..3
//  speed_valid  out  1  high in ARM and RUN (speed_level is committed)
//  move_tick    out  1  1-cycle game step pulse
//  state_dbg    out  2  current FSM state encoding
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, menu_active=0, speed_level=2'd1,
//   speed_valid=0, move_tick=0, counter=0. All outputs are registered.
//  FSM states: IDLE=2'b00, MENU=2'b01, ARM=2'b10, RUN=2'b11.
//  IDLE: start_req -> MENU. All key pulses are ignored.
//  MENU: menu_active=1.
//   - game_over -> IDLE. game_over wins over a key in the same cycle.
//   - Any key pulse -> latch the level, then ARM.
//   - Simultaneous keys: priority is up > down > left > right.
//   - start_req is ignored.
//  ARM: exactly 1 cycle. counter<=0, speed_valid=1, then RUN.
//  RUN: speed_valid=1. Period P = DIV_* selected by speed_level.
//   - Counter update:
//     - pause=1: hold the counter.
//     - else if counter==P-1: counter<=0.
//     - else: counter<=counter+1.
//   - move_tick<=1 on the edge where state==RUN, pause==0, game_over==0 and
//     counter==P-1. Otherwise move_tick<=0.
//   - Result: with cycle 1 = first RUN cycle, move_tick is high in cycles
//     P+1, 2P+1, ... Each pause cycle shifts later ticks by 1.
//   - game_over -> IDLE. Clear the counter and speed_valid. Suppress any tick
//     in that cycle. Keys and start_req are ignored.
//  speed_level holds its value through IDLE. It changes only on a MENU key.
//  menu_active changes state on the same edge as the state register.
//  Divider compare is unsigned at CNT_W bits. The counter never exceeds P-1.
//  Async reset in any state returns to reset values immediately.
//  No tick is produced after reset is released until RUN is re-entered.
// TESTING (bench params DIV_FAST=4 DIV_NORM=6 DIV_SLOW=8 DIV_VSLOW=10)
//  Reset: rst_n=0 -> menu_active=0, speed_level=1, speed_valid=0,
//   move_tick=0, state_dbg=00.
//  start_req, then key_up 3 cycles later -> MENU, then ARM (1 cycle), then RUN.
//   speed_level=0 and move_tick is high in RUN cycles 5, 9, 13.
//  In MENU, key_down and key_right in the same cycle -> speed_level=1.
//   Ticks are spaced 6 cycles apart.
//  RUN level 2, pause held 3 cycles starting at RUN cycle 4 -> first tick
//   in cycle 12, next in cycle 20.
//  game_over in the cycle where counter==P-1 -> no move_tick, then IDLE.
//   speed_valid=0 and speed_level is retained.
//  rst_n pulsed low mid-RUN, asynchronous to the clock -> outputs are at
//   reset values before the next edge. Key pulses after release are ignored
//   until start_req.

Source files
------------

// File: rtl/speed_select_ctrl.sv
// Speed-selection menu sequencer and movement timebase.
// IDLE -> MENU on start_req, MENU latches a level from a key pulse, ARM clears
// the divider for one cycle, RUN emits a registered move_tick every P clocks.
module speed_select_ctrl #(
  parameter int unsigned DIV_FAST  = 2_500_000,
  parameter int unsigned DIV_NORM  = 5_000_000,
  parameter int unsigned DIV_SLOW  = 7_500_000,
  parameter int unsigned DIV_VSLOW = 12_500_000,
  parameter int unsigned CNT_W     = 24
) (
  input  logic       vga_clk_25,
  input  logic       rst_n,
  input  logic       start_req,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       pause,
  input  logic       game_over,
  output logic       menu_active,
  output logic [1:0] speed_level,
  output logic       speed_valid,
  output logic       move_tick,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMenu = 2'b01,
    StArm  = 2'b10,
    StRun  = 2'b11
  } state_e;

  // Terminal counts (P-1) truncated to the counter width.
  localparam logic [CNT_W-1:0] FastM1  = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] NormM1  = CNT_W'(DIV_NORM - 1);
  localparam logic [CNT_W-1:0] SlowM1  = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] VslowM1 = CNT_W'(DIV_VSLOW - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_m1;
  logic [1:0]       level_q, level_d;
  logic             menu_q, menu_d;
  logic             valid_q, valid_d;
  logic             tick_q, tick_d;
  logic             any_key;

  assign any_key = key_up | key_down | key_left | key_right;

  // Terminal count for the currently latched speed level.
  always_comb begin
    period_m1 = NormM1;
    unique case (level_q)
      2'd0:    period_m1 = FastM1;
      2'd1:    period_m1 = NormM1;
      2'd2:    period_m1 = SlowM1;
      default: period_m1 = VslowM1;
    endcase
  end

  // Next-state, level latch, divider and tick generation.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_req) state_d = StMenu;
      end
      StMenu: begin
        // game_over outranks a simultaneous key.
        if (game_over) begin
          state_d = StIdle;
        end else if (any_key) begin
          state_d = StArm;
          if (key_up)        level_d = 2'd0;
          else if (key_down) level_d = 2'd1;
          else if (key_left) level_d = 2'd2;
          else               level_d = 2'd3;
        end
      end
      StArm: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      default: begin
        if (game_over) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!pause) begin
          if (cnt_q == period_m1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
    // Outputs derived from the next state so they move on the same edge.
    menu_d  = (state_d == StMenu);
    valid_d = (state_d == StArm) || (state_d == StRun);
  end

  // State and registered outputs, async active-low reset.
  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      level_q <= 2'd1;
      menu_q  <= 1'b0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      menu_q  <= menu_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
    end
  end

  assign menu_active = menu_q;
  assign speed_level = level_q;
  assign speed_valid = valid_q;
  assign move_tick   = tick_q;
  assign state_dbg   = state_q;

endmodule
